tpu_tile_gemm: RTL

- Parametrised GEMM engine computing C[MxN] = A[MxK] · B[KxN] with signed INT8 operands and signed ACC_W accumulators.
- Sits between the host job interface (in_valid/K/M/N/busy) and the A, B and C global buffers.
- Walks the output in PxP tiles. A PxP outer-product MAC array accumulates one K-slice per cycle. Finished tile rows are written back to C.
- Replaces the fixed stub engine with real tiling, dimension handling and a done pulse.

---
 rtl/tpu_pkg.sv | 11 +
 rtl/tpu_tile_gemm_if.sv | 25 ++
 rtl/tpu_mac_pe.sv | 29 ++
 rtl/tpu_tile_gemm.sv | 116 +++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared FSM states, MAC pipeline depth and tiling helpers for the GEMM tile engine
package tpu_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
  localparam int MAC_LAT = 3;
  function automatic logic [7:0] tile_cnt(input logic [7:0] d, input int p);
    return 8'((32'(d) + 32'(p) - 32'd1) / 32'(p));
  endfunction
  function automatic logic [7:0] lane8(input logic [63:0] w, input int i);
    return w[8*i +: 8];
  endfunction
endpackage

// File: rtl/tpu_tile_gemm_if.sv
// tpu_tile_gemm_if: host job handshake plus A/B/C global buffer ports of the GEMM engine
interface tpu_tile_gemm_if #(
  parameter int P = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W = 32,
  parameter int IDX_W = 16
);
  logic in_valid;
  logic [7:0] K, M, N;
  logic busy, done;
  logic A_wr_en, B_wr_en, C_wr_en;
  logic [IDX_W-1:0] A_index, B_index, C_index;
  logic [P*DATA_W-1:0] A_data_in, A_data_out, B_data_in, B_data_out;
  logic [P*ACC_W-1:0] C_data_in, C_data_out;
  modport master (
    input in_valid, K, M, N, A_data_out, B_data_out, C_data_out,
    output busy, done, A_wr_en, A_index, A_data_in, B_wr_en, B_index, B_data_in,
    C_wr_en, C_index, C_data_in
  );
  modport slave (
    output in_valid, K, M, N, A_data_out, B_data_out, C_data_out,
    input busy, done, A_wr_en, A_index, A_data_in, B_wr_en, B_index, B_data_in,
    C_wr_en, C_index, C_data_in
  );
endinterface

// File: rtl/tpu_mac_pe.sv
// tpu_mac_pe: one signed multiply stage followed by a clear-or-accumulate register
module tpu_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic first,
  input logic signed [DATA_W-1:0] a,
  input logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic en_q, first_q;
  // product register, then overwrite on the first K-slice of a tile and wrap-add afterwards
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod <= '0;
      en_q <= 1'b0;
      first_q <= 1'b0;
      acc <= '0;
    end else begin
      prod <= a * b;
      en_q <= en;
      first_q <= first;
      if (en_q) acc <= first_q ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
endmodule

// File: rtl/tpu_tile_gemm.sv
// tpu_tile_gemm: tiled INT8 GEMM engine walking C in PxP tiles over the A/B/C buffers
module tpu_tile_gemm
  import tpu_pkg::*;
#(
  parameter int P = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W = 32,
  parameter int IDX_W = 16
) (
  input logic clk,
  input logic rst,
  tpu_tile_gemm_if.master bus
);
  state_t state, state_n;
  logic [7:0] kd, md, mtc, ntc, cnt, cnt_n, mt, mt_n, nt, nt_n;
  logic v1, f1, last_t, unused_c;
  logic [IDX_W-1:0] row_n;
  logic [P*ACC_W-1:0] crow;
  logic signed [ACC_W-1:0] acc [P][P];
  assign unused_c = ^bus.C_data_out;
  assign bus.A_wr_en = 1'b0;
  assign bus.B_wr_en = 1'b0;
  assign bus.A_data_in = '0;
  assign bus.B_data_in = '0;
  // next state plus k/drain/row counter and tile stepping (mt inner, nt outer)
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mt_n = mt;
    nt_n = nt;
    last_t = (mt == mtc - 8'd1) && (nt == ntc - 8'd1);
    case (state)
      IDLE: if (bus.in_valid) begin
        state_n = (bus.K == 8'd0 || bus.M == 8'd0 || bus.N == 8'd0) ? DONE : FETCH;
        cnt_n = '0;
        mt_n = '0;
        nt_n = '0;
      end
      FETCH: begin
        state_n = (cnt == kd - 8'd1) ? DRAIN : FETCH;
        cnt_n = (cnt == kd - 8'd1) ? 8'd0 : cnt + 8'd1;
      end
      DRAIN: begin
        state_n = (cnt == 8'(MAC_LAT - 1)) ? WRITE : DRAIN;
        cnt_n = (cnt == 8'(MAC_LAT - 1)) ? 8'd0 : cnt + 8'd1;
      end
      WRITE: if (cnt == 8'(P - 1)) begin
        state_n = last_t ? DONE : FETCH;
        cnt_n = '0;
        mt_n = (mt == mtc - 8'd1) ? 8'd0 : mt + 8'd1;
        nt_n = (mt == mtc - 8'd1) ? nt + 8'd1 : nt;
      end else cnt_n = cnt + 8'd1;
      default: state_n = IDLE;
    endcase
  end
  // row and accumulator word for the C write issued on the coming edge
  always_comb begin
    row_n = IDX_W'(mt_n) * IDX_W'(P) + IDX_W'(cnt_n);
    crow = '0;
    for (int r = 0; r < P; r++)
      for (int j = 0; j < P; j++)
        if (cnt_n == 8'(r)) crow[ACC_W*j +: ACC_W] = acc[r][j];
  end
  // state, job registers, data-aligned valid/first flags and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {cnt, mt, nt, kd, md, mtc, ntc} <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.A_index <= '0;
      bus.B_index <= '0;
      bus.C_wr_en <= 1'b0;
      bus.C_index <= '0;
      bus.C_data_in <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mt <= mt_n;
      nt <= nt_n;
      if (state == IDLE && bus.in_valid) begin
        kd <= bus.K;
        md <= bus.M;
        mtc <= tile_cnt(bus.M, P);
        ntc <= tile_cnt(bus.N, P);
      end
      v1 <= state == FETCH;
      f1 <= state == FETCH && cnt == 8'd0;
      bus.busy <= state_n != IDLE;
      bus.done <= state_n == DONE;
      if (state_n == FETCH) begin
        bus.A_index <= IDX_W'(mt_n) * IDX_W'(kd) + IDX_W'(cnt_n);
        bus.B_index <= IDX_W'(nt_n) * IDX_W'(kd) + IDX_W'(cnt_n);
      end
      bus.C_wr_en <= state_n == WRITE && row_n < IDX_W'(md);
      if (state_n == WRITE) begin
        bus.C_index <= IDX_W'(nt_n) * IDX_W'(mtc) * IDX_W'(P) + row_n;
        bus.C_data_in <= crow;
      end
    end
  for (genvar i = 0; i < P; i++) begin : g_r
    for (genvar j = 0; j < P; j++) begin : g_c
      tpu_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk),
        .rst(rst),
        .en(v1),
        .first(f1),
        .a(bus.A_data_out[DATA_W*i +: DATA_W]),
        .b(bus.B_data_out[DATA_W*j +: DATA_W]),
        .acc(acc[i][j])
      );
    end
  end
endmodule
